data_mem_responder: RTL and testbench

// - Memory-side responder for the MEM stage: accepts one load/store request at a time over valid/ready,

---
 rtl/data_mem_responder_pkg.sv | 23 ++
 rtl/data_mem_array.sv | 27 ++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 tb/tb_data_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
// The state encoding, default RAM depth and write-enable polarity live here.
package data_mem_responder_pkg;

  localparam int   RAM_ADDRESS_BITWIDTH = 10;
  localparam logic RAM_WRITE_ENABLE     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_READ   = 3'd3,
    ST_RESP   = 3'd4
  } mem_rsp_state_e;

  // Misaligned or beyond the word array (no wrap-around of high address bits).
  function automatic logic addr_is_bad(input logic [31:0] addr, input int aw);
    logic [31:0] w_hi;
    w_hi = addr >> (aw + 2);
    return (addr[1:0] != 2'b00) || (w_hi != 32'd0);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word RAM with one-cycle registered read latency.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDRESS_BITWIDTH
) (
  input  logic                  clk,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data
);

  logic [31:0] r_mem [0:(1 << ADDR_WIDTH)-1];
  logic [31:0] r_read_data;

  // Storage has no reset so contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (wren == RAM_WRITE_ENABLE) begin
      r_mem[address] <= write_data;
    end
    r_read_data <= r_mem[address];
  end

  assign read_data = r_read_data;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage responder: one load/store at a time over valid/ready, serviced
// against a synchronous word RAM after WAIT_CYCLES wait states.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = RAM_ADDRESS_BITWIDTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  mem_rsp_state_e        r_state;
  logic [7:0]            r_wait_cnt;
  logic                  r_wren;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [31:0]           r_wdata;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_error;
  logic                  w_ram_wren;
  logic [31:0]           w_ram_rdata;

  // The array is written only during the single ACCESS cycle of a store.
  assign w_ram_wren = ((r_state == ST_ACCESS) && (r_wren == RAM_WRITE_ENABLE))
                    ? RAM_WRITE_ENABLE : ~RAM_WRITE_ENABLE;

  data_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk       (clk),
    .wren      (w_ram_wren),
    .address   (r_index),
    .write_data(r_wdata),
    .read_data (w_ram_rdata)
  );

  // Request/response FSM; rsp_valid rises one edge after RESP is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 8'd0;
      r_wren      <= 1'b0;
      r_index     <= '0;
      r_wdata     <= 32'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_req_ready) begin
            r_req_ready <= 1'b1;
          end else if (req_valid) begin
            r_req_ready <= 1'b0;
            r_wren      <= req_wren;
            r_index     <= req_addr[ADDR_WIDTH+1:2];
            r_wdata     <= req_wdata;
            if (addr_is_bad(req_addr, ADDR_WIDTH)) begin
              r_rsp_error <= 1'b1;
              r_rsp_rdata <= 32'd0;
              r_state     <= ST_RESP;
            end else if (WAIT_CYCLES == 0) begin
              r_state <= ST_ACCESS;
            end else begin
              r_wait_cnt <= WAIT_LOAD;
              r_state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 8'd0) begin
            r_state <= ST_ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end
        end
        ST_ACCESS: begin
          r_rsp_error <= 1'b0;
          r_rsp_rdata <= 32'd0;
          r_state     <= (r_wren == RAM_WRITE_ENABLE) ? ST_RESP : ST_READ;
        end
        ST_READ: begin
          r_rsp_rdata <= w_ram_rdata;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: dut0 (ADDR_WIDTH=10, WAIT_CYCLES=2) and dut1 (ADDR_WIDTH=4, WAIT_CYCLES=0)
// checked against an address-map/latency model kept in associative arrays.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_wren;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  wire  [1:0]       req_ready;
  wire  [1:0]       rsp_valid;
  wire  [1:0]       rsp_error;
  wire  [1:0][31:0] rsp_rdata;

  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  bit   have[2];
  bit   rnd_rdy = 1'b0;
  logic [31:0] mem0 [int];
  logic [31:0] mem1 [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wren(req_wren[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_error(rsp_error[0]));

  data_mem_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wren(req_wren[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_error(rsp_error[1]));

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  function automatic bit known(input int d, input int idx);
    if (d == 0) return mem0.exists(idx);
    return mem1.exists(idx);
  endfunction

  function automatic int qsize(input int d);
    if (d == 0) return q0.size();
    return q1.size();
  endfunction

  // Issue one request; the model decides error/latency/data from the address map.
  task automatic issue(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t   e;
    int     n;
    int     aw;
    int     w;
    int     idx;
    bit     bad;
    aw  = (d == 0) ? 10 : 4;
    w   = (d == 0) ? 2 : 0;
    n   = 0;
    while (!req_ready[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk("accept_timeout", d, 32'd1, 32'd0);
      return;
    end
    req_valid[d] = 1'b1;
    req_wren[d]  = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    bad = (addr % 4 != 0) || (longint'(addr) >= (longint'(4) << aw));
    idx = int'(addr / 4);
    e.acc = cyc + 1;
    e.err = bad;
    if (bad) begin
      e.lat = 1;
      e.rdata = 32'd0;
    end else if (wr) begin
      e.lat = w + 2;
      e.rdata = 32'd0;
      if (d == 0) mem0[idx] = wdata;
      else        mem1[idx] = wdata;
    end else begin
      e.lat = w + 3;
      if (d == 0) e.rdata = mem0.exists(idx) ? mem0[idx] : 32'd0;
      else        e.rdata = mem1.exists(idx) ? mem1[idx] : 32'd0;
    end
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while ((qsize(d) != 0 || have[d] || !req_ready[d]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", d, 32'd1, 32'd0);
  endtask

  task automatic rand_ops(input int d, input int nops);
    for (int i = 0; i < nops; i++) begin
      int          slot;
      int          r;
      bit          wr;
      logic [31:0] a;
      slot = $urandom_range(0, 15);
      a  = (d == 0) ? 32'(slot * 4 + 256) : 32'(slot * 4);
      wr = ($urandom_range(0, 1) == 1) || !known(d, int'(a / 4));
      r  = $urandom_range(0, 9);
      if (r == 0)      a = a | 32'd2;
      else if (r == 1) a = a + ((d == 0) ? 32'h1000 : 32'h40);
      issue(d, wr, a, $urandom);
    end
  endtask

  // Monitor: pops the expectation on first rsp_valid, then checks stability each cycle.
  always @(negedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        have[d] = 1'b0;
      end else if (rsp_valid[d]) begin
        if (!have[d]) begin
          have[d] = 1'b1;
          if (qsize(d) == 0) begin
            chk("unexpected_rsp", d, 32'd1, 32'd0);
            cur[d].rdata = rsp_rdata[d];
            cur[d].err   = rsp_error[d];
          end else begin
            if (d == 0) cur[d] = q0.pop_front();
            else        cur[d] = q1.pop_front();
            chk("latency", d, 32'(cyc - cur[d].acc), 32'(cur[d].lat));
          end
        end
        chk("rsp_rdata", d, rsp_rdata[d], cur[d].rdata);
        chk("rsp_error", d, 32'(rsp_error[d]), 32'(cur[d].err));
        chk("req_ready_busy", d, 32'(req_ready[d]), 32'd0);
        if (rsp_ready[d]) have[d] = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 2'b11; req_valid = 2'b00; req_wren = 2'b00; rsp_ready = 2'b11;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", d, 32'(req_ready[d]), 32'd0);
      chk("reset_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
      chk("reset_rsp_rdata", d, rsp_rdata[d], 32'd0);
      chk("reset_rsp_error", d, 32'(rsp_error[d]), 32'd0);
    end
    rst = 2'b00;
    #1;
    chk("release_req_ready_0", 0, 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    chk("release_req_ready_1", 0, 32'(req_ready[0]), 32'd1);
    chk("release_req_ready_1", 1, 32'(req_ready[1]), 32'd1);

    // Basic store/load and error cases on dut0.
    issue(0, 1'b1, 32'h0000_0000, 32'hA5A5_0000);
    issue(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'h0000_0010, 32'h0);
    issue(0, 1'b1, 32'h0000_0013, 32'hFFFF_FFFF);
    issue(0, 1'b0, 32'h0000_0013, 32'h0);
    issue(0, 1'b1, 32'h0000_1000, 32'h1111_2222);
    issue(0, 1'b0, 32'h0000_1000, 32'h0);
    issue(0, 1'b0, 32'h0000_0010, 32'h0);
    issue(0, 1'b0, 32'h0000_0000, 32'h0);
    issue(0, 1'b0, 32'h0000_0FFC, 32'h0);
    wait_idle(0);

    // Backpressure with ignored request pulses.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h0000_0010, 32'h0);
    n = 0;
    while (!rsp_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("bp_rsp_timeout", 0, 32'd1, 32'd0);
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = (i % 2 == 0);
      req_wren[0]  = 1'b1;
      req_addr[0]  = 32'h0;
      req_wdata[0] = 32'hBAD0_0000 + 32'(i);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    #2;
    chk("bp_release_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("bp_release_req_ready", 0, 32'(req_ready[0]), 32'd1);
    issue(0, 1'b0, 32'h0000_0000, 32'h0);
    wait_idle(0);

    // Reset during WAIT of a store must leave the word unchanged.
    issue(0, 1'b1, 32'h0000_0020, 32'h0);
    wait_idle(0);
    req_valid[0] = 1'b1; req_wren[0] = 1'b1;
    req_addr[0] = 32'h0000_0020; req_wdata[0] = 32'h1234_5678;
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 0, 32'(req_ready[0]), 32'd0);
    chk("midrst_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    rst[0] = 1'b0;
    repeat (6) @(negedge clk);
    issue(0, 1'b0, 32'h0000_0020, 32'h0);
    wait_idle(0);

    // Zero wait states, last word and boundary errors on dut1.
    issue(1, 1'b1, 32'h0000_003C, 32'hCAFE_F00D);
    issue(1, 1'b0, 32'h0000_003C, 32'h0);
    issue(1, 1'b0, 32'h0000_0040, 32'h0);
    issue(1, 1'b1, 32'h0000_0041, 32'h5555_AAAA);
    issue(1, 1'b0, 32'h0000_003C, 32'h0);
    wait_idle(1);

    // Randomized traffic with random response backpressure.
    rnd_rdy = 1'b1;
    fork
      begin
        while (rnd_rdy) begin
          @(negedge clk);
          rsp_ready = 2'($urandom);
        end
      end
      begin
        rand_ops(0, 40);
        rand_ops(1, 40);
        rnd_rdy = 1'b0;
      end
    join
    rsp_ready = 2'b11;
    wait_idle(0);
    wait_idle(1);
    chk("queue_empty", 0, 32'(qsize(0)), 32'd0);
    chk("queue_empty", 1, 32'(qsize(1)), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
